// File: rtl/cnn_layer_1_pkg.sv
// cnn_layer_1_pkg: default geometry, widths and saturation limits
// shared by the layer-1 bias/ReLU/pool slice (option: CNN_LAYER_1_RELU_EN).
package cnn_layer_1_pkg;

  localparam int ACC_BW  = 26;
  localparam int BIAS_BW = 16;
  localparam int OUT_BW  = 8;
  localparam int SHIFT   = 8;
  localparam int CONV_W  = 24;
  localparam int CONV_H  = 24;

  localparam int COL_BW = $clog2(CONV_W);
  localparam int ROW_BW = $clog2(CONV_H);

  localparam int OUT_MAX = (2 ** (OUT_BW - 1)) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_BW - 1));

  // Largest signed value representable in bw bits
  function automatic int sat_max(input int bw);
    return (2 ** (bw - 1)) - 1;
  endfunction

  // Smallest signed value representable in bw bits
  function automatic int sat_min(input int bw);
    return -(2 ** (bw - 1));
  endfunction

endpackage

// File: rtl/cnn_layer_1_requant.sv
// cnn_layer_1_requant: bias add, arithmetic shift, clamp, registered.
// CNN_LAYER_1_RELU_EN selects a lower clamp of 0 instead of the signed minimum.
module cnn_layer_1_requant #(
  parameter int ACC_BW  = cnn_layer_1_pkg::ACC_BW,
  parameter int BIAS_BW = cnn_layer_1_pkg::BIAS_BW,
  parameter int OUT_BW  = cnn_layer_1_pkg::OUT_BW,
  parameter int SHIFT   = cnn_layer_1_pkg::SHIFT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              soft_reset,
  input  logic              in_valid,
  input  logic [ACC_BW-1:0] in_sum,
  input  logic [BIAS_BW-1:0] bias,
  output logic              act_valid,
  output logic [OUT_BW-1:0] act
);

  localparam logic signed [ACC_BW:0] HI =
    (ACC_BW + 1)'(cnn_layer_1_pkg::sat_max(OUT_BW));
`ifdef CNN_LAYER_1_RELU_EN
  localparam logic signed [ACC_BW:0] LO = '0;
`else
  localparam logic signed [ACC_BW:0] LO =
    (ACC_BW + 1)'(cnn_layer_1_pkg::sat_min(OUT_BW));
`endif

  logic signed [ACC_BW:0] t;
  logic signed [ACC_BW:0] s;
  logic [OUT_BW-1:0]      q;

  // One guard bit keeps the sum exact; the shift floors toward -inf
  always_comb begin
    t = {in_sum[ACC_BW-1], in_sum}
      + {{(ACC_BW + 1 - BIAS_BW){bias[BIAS_BW-1]}}, bias};
    s = t >>> SHIFT;
    if (s > HI) begin
      q = HI[OUT_BW-1:0];
    end else if (s < LO) begin
      q = LO[OUT_BW-1:0];
    end else begin
      q = s[OUT_BW-1:0];
    end
  end

  // Output register; soft_reset drops whatever is in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_valid <= 1'b0;
      act       <= '0;
    end else if (soft_reset) begin
      act_valid <= 1'b0;
    end else begin
      act_valid <= in_valid;
      if (in_valid) begin
        act <= q;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_1_bias_relu_pool.sv
// cnn_layer_1_bias_relu_pool: requantize each conv pixel, then 2x2/2 max pool.
// CNN_LAYER_1_RELU_EN enables ReLU in the requantizer.
module cnn_layer_1_bias_relu_pool #(
  parameter int ACC_BW  = cnn_layer_1_pkg::ACC_BW,
  parameter int BIAS_BW = cnn_layer_1_pkg::BIAS_BW,
  parameter int OUT_BW  = cnn_layer_1_pkg::OUT_BW,
  parameter int SHIFT   = cnn_layer_1_pkg::SHIFT,
  parameter int CONV_W  = cnn_layer_1_pkg::CONV_W,
  parameter int CONV_H  = cnn_layer_1_pkg::CONV_H
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               soft_reset,
  input  logic               in_valid,
  input  logic [ACC_BW-1:0]  in_sum,
  input  logic [BIAS_BW-1:0] bias,
  output logic               out_valid,
  output logic [OUT_BW-1:0]  out_data,
  output logic               out_last
);

  localparam int COL_BW = $clog2(CONV_W);
  localparam int ROW_BW = $clog2(CONV_H);
  localparam int HALF_W = CONV_W / 2;

  localparam logic [COL_BW-1:0] COL_END = COL_BW'(CONV_W - 1);
  localparam logic [ROW_BW-1:0] ROW_END = ROW_BW'(CONV_H - 1);

  logic [COL_BW-1:0] col;
  logic [ROW_BW-1:0] row;
  logic [COL_BW-1:0] act_col;
  logic [ROW_BW-1:0] act_row;

  logic              act_valid;
  logic [OUT_BW-1:0] act;

  logic signed [OUT_BW-1:0] act_s;
  logic signed [OUT_BW-1:0] h_hold;
  logic signed [OUT_BW-1:0] hmax;
  logic signed [OUT_BW-1:0] buf_rd;
  logic signed [OUT_BW-1:0] vmax;
  logic [COL_BW-2:0]        half;
  logic                     take;

  logic signed [OUT_BW-1:0] row_buf [HALF_W];

  cnn_layer_1_requant #(
    .ACC_BW (ACC_BW),
    .BIAS_BW(BIAS_BW),
    .OUT_BW (OUT_BW),
    .SHIFT  (SHIFT)
  ) u_requant (
    .clk       (clk),
    .reset_n   (reset_n),
    .soft_reset(soft_reset),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .bias      (bias),
    .act_valid (act_valid),
    .act       (act)
  );

  // Raster position of the next input, and of the pixel now in stage 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col     <= '0;
      row     <= '0;
      act_col <= '0;
      act_row <= '0;
    end else if (soft_reset) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      act_col <= col;
      act_row <= row;
      if (col == COL_END) begin
        col <= '0;
        row <= (row == ROW_END) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Horizontal pair max, then vertical max against the buffered even row
  always_comb begin
    act_s  = act;
    half   = act_col[COL_BW-1:1];
    take   = act_valid && !soft_reset;
    hmax   = (act_s > h_hold) ? act_s : h_hold;
    buf_rd = row_buf[half];
    vmax   = (buf_rd > hmax) ? buf_rd : hmax;
  end

  // Half-row buffer: filled on even rows, consumed on odd rows
  always_ff @(posedge clk) begin
    if (take && act_col[0] && !act_row[0]) begin
      row_buf[half] <= hmax;
    end
  end

  // Pool output register; valid and last are single-cycle pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_hold    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (take) begin
        if (!act_col[0]) begin
          h_hold <= act_s;
        end else if (act_row[0]) begin
          out_valid <= 1'b1;
          out_data  <= vmax;
          out_last  <= (act_col == COL_END) && (act_row == ROW_END);
        end
      end
    end
  end

endmodule
